// File: rtl/lsu_pkg.sv
// Shared encodings and the latched-request record for the load/store unit.
package lsu_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  // Alignment legality of a request; out-of-range is checked separately.
  function automatic logic misaligned(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: load extract/extend and store merge, purely combinational.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] st_old,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh = {off, 3'b000};
  assign b  = ld_word[sh +: 8];
  assign h  = off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    case (size)
      SZ_BYTE: ld_data = {{24{~uns & b[7]}}, b};
      SZ_HALF: ld_data = {{16{~uns & h[15]}}, h};
      default: ld_data = ld_word;
    endcase
  end

  // Each lane takes new data when targeted, else keeps the old RAM byte.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic hit_b, hit_h;
    assign hit_b = (size == SZ_BYTE) && (off == 2'(i));
    assign hit_h = (size == SZ_HALF) && (off[1] == 1'(i / 2));
    assign st_word[8*i +: 8] = hit_b            ? wdata[7:0] :
                               hit_h            ? wdata[8*(i%2) +: 8] :
                               (size == SZ_WORD) ? wdata[8*i +: 8] :
                                                   st_old[8*i +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word RAM, sub-word stores via read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  state_e      state;
  lsu_req_t    rq;
  logic        rej;
  logic        bad;
  logic [31:0] merge_q;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        word_st;

  assign bad = misaligned(size_e'(size), addr[1:0]) ||
               ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));

  lsu_lane u_lane (
    .ld_word (mem_dout),
    .st_old  (merge_q),
    .wdata   (rq.wdata),
    .off     (rq.off),
    .size    (rq.size),
    .uns     (rq.uns),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rq       <= '0;
      rej      <= 1'b0;
      merge_q  <= '0;
      rdata    <= '0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          rq       <= '{we: we, size: size_e'(size), uns: uns, off: addr[1:0], wdata: wdata};
          mem_addr <= {2'b00, addr[31:2]};
          rej      <= bad;
          state    <= bad ? RESP : ACCESS;
        end
        ACCESS: begin
          if (!rq.we) begin
            rdata <= ld_data;
            state <= RESP;
          end else if (rq.size == SZ_WORD) begin
            state <= RESP;
          end else begin
            merge_q <= mem_dout;
            state   <= WRITE;
          end
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe decoded from state so an async reset kills it immediately.
  assign word_st = rq.we && (rq.size == SZ_WORD);
  assign mem_we  = ((state == ACCESS) && word_st) || (state == WRITE);
  assign mem_din = mem_we ? st_word : '0;
  assign ready   = (state == IDLE);
  assign done    = (state == RESP);
  assign err     = done && rej;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a behavioural 32-word RAM.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, done, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;

  logic [31:0] ram [0:31];
  logic        pre_en = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = '0;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0;
  int acc_t [0:7];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  assign mem_dout = (mem_addr < 32) ? ram[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[4:0]] <= mem_din;
    else if (pre_en) ram[pre_idx[4:0]] <= pre_val;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (req && ready) begin
      if (acc_cnt < 8) acc_t[acc_cnt] = cyc;
      acc_cnt = acc_cnt + 1;
    end
  end

  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    int          pidx;
    logic [31:0] pval;
    logic        xerr;
    int          xlat;
    logic [31:0] xrdata;
    int          cidx;
    logic [31:0] xram;
    int          xwe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [1:0] s, logic u, logic [31:0] a, logic [31:0] d,
                              logic p, int pi, logic [31:0] pv, logic xe, int xl,
                              logic [31:0] xr, int ci, logic [31:0] xm, int xw);
    vec_t v;
    v.we = w; v.size = s; v.uns = u; v.addr = a; v.wdata = d;
    v.pre = p; v.pidx = pi; v.pval = pv; v.xerr = xe; v.xlat = xl;
    v.xrdata = xr; v.cidx = ci; v.xram = xm; v.xwe = xw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t t);
    int k, wecnt;
    logic got, gerr;
    logic [31:0] din;
    if (t.pre) preload(t.pidx, t.pval);
    @(negedge clk);
    req = 1'b1; we = t.we; size = t.size; uns = t.uns; addr = t.addr; wdata = t.wdata;
    @(posedge clk);
    #1;
    req = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom); uns = 1'($urandom);
    we = 1'($urandom);
    k = 0; wecnt = 0; got = 1'b0; gerr = 1'b0; din = '0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      if (mem_we) begin wecnt++; din = mem_din; end
      if (done) begin got = 1'b1; gerr = err; end
    end
    chk($sformatf("v%0d latency", n), 32'(k), 32'(t.xlat));
    chk($sformatf("v%0d err", n), {31'b0, gerr}, {31'b0, t.xerr});
    chk($sformatf("v%0d rdata", n), rdata, t.xrdata);
    chk($sformatf("v%0d mem_we cycles", n), 32'(wecnt), 32'(t.xwe));
    if (t.cidx >= 0) begin
      chk($sformatf("v%0d ram[%0d]", n, t.cidx), ram[t.cidx], t.xram);
      if (t.xwe > 0) chk($sformatf("v%0d mem_din", n), din, t.xram);
    end
  endtask

  initial begin
    int k;
    int d0;

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst rdata", rdata, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_din", mem_din, 32'h0);
    #19 rst_n = 1'b1;

    // reset mid-operation: request lost, no done
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("busy ready", {31'b0, ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst ready", {31'b0, ready}, 32'd1);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("midrst no done", 32'(done_cnt - d0), 32'd0);

    vecs.push_back(mk(0, 2'b10, 0, 32'h20, 0, 1, 8,  32'h00000013, 0, 2, 32'h00000013, -1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h7B, 0, 1, 30, 32'hFFFFFFF3, 0, 2, 32'hFFFFFFFF, -1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h7C, 0, 1, 31, 32'hEEEEEEE3, 0, 2, 32'h000000E3, -1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h7E, 0, 0, 0,  0,            0, 2, 32'hFFFFEEEE, -1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h21, 32'h000000AB, 1, 8, 32'h11223344, 0, 3, 32'hFFFFEEEE, 8, 32'h1122AB44, 1));
    vecs.push_back(mk(1, 2'b01, 0, 32'h22, 32'h0000BEEF, 0, 0, 0, 0, 3, 32'hFFFFEEEE, 8, 32'hBEEFAB44, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h02, 0, 0, 0, 0, 1, 1, 32'hFFFFEEEE, -1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h05, 0, 0, 0, 0, 1, 1, 32'hFFFFEEEE, -1, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h80, 0, 0, 0, 0, 1, 1, 32'hFFFFEEEE, -1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h00, 0, 0, 0, 0, 1, 1, 32'hFFFFEEEE, -1, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h04, 32'h0BADBEEF, 0, 0, 0, 0, 2, 32'hFFFFEEEE, 1, 32'h0BADBEEF, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h04, 0, 0, 0, 0, 0, 2, 32'h0BADBEEF, -1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h22, 0, 0, 0, 0, 0, 2, 32'h0000BEEF, -1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h22, 0, 0, 0, 0, 0, 2, 32'hFFFFBEEF, -1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h21, 0, 0, 0, 0, 0, 2, 32'hFFFFFFAB, -1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h23, 0, 0, 0, 0, 0, 2, 32'h000000BE, -1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h7F, 32'h12345655, 0, 0, 0, 0, 3, 32'h000000BE, 31, 32'h55EEEEE3, 1));
    vecs.push_back(mk(1, 2'b11, 0, 32'h04, 32'h0, 0, 0, 0, 1, 1, 32'h000000BE, 1, 32'h0BADBEEF, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h7D, 32'h0, 0, 0, 0, 1, 1, 32'h000000BE, 31, 32'h55EEEEE3, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h7C, 32'hFFFF7777, 0, 0, 0, 0, 3, 32'h000000BE, 31, 32'h55EE7777, 1));
    vecs.push_back(mk(0, 2'b01, 0, 32'h7C, 0, 0, 0, 0, 0, 2, 32'h00007777, -1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'hFC, 32'h11, 0, 0, 0, 1, 1, 32'h00007777, -1, 0, 0));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // back-to-back with req held high while busy
    @(negedge clk);
    acc_cnt = 0; d0 = done_cnt;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 we = 1'b0; wdata = 32'h0;
    k = 0;
    while (acc_cnt < 2 && k < 12) begin @(negedge clk); k++; end
    req = 1'b0;
    k = 0;
    while (done_cnt - d0 < 2 && k < 12) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("b2b accepts", 32'(acc_cnt), 32'd2);
    chk("b2b dones", 32'(done_cnt - d0), 32'd2);
    chk("b2b spacing", (acc_cnt >= 2) ? 32'(acc_t[1] - acc_t[0]) : 32'hFFFFFFFF, 32'd3);
    chk("b2b ram[0]", ram[0], 32'hCAFEF00D);
    chk("b2b rdata", rdata, 32'hCAFEF00D);

    // reset during the WRITE cycle of a byte store
    preload(5, 32'h01020304);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h14; wdata = 32'hFF;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rmw write phase mem_we", {31'b0, mem_we}, 32'd1);
    chk("rmw write phase mem_din", mem_din, 32'h010203FF);
    #1 rst_n = 1'b0;
    #1;
    chk("rmw rst mem_we", {31'b0, mem_we}, 32'd0);
    d0 = done_cnt;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rmw rst ram[5]", ram[5], 32'h01020304);
    chk("rmw rst no done", 32'(done_cnt - d0), 32'd0);
    chk("rmw rst ready", {31'b0, ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
